stopwatch_timer: RTL and testbench
==================================

Name: stopwatch_timer

Overview:
- Synchronous stopwatch: a prescaler derives a one-cycle tick from the system clock, and a chain of BCD digit counters counts ticks.
- Controlled by start/stop/clear levels from the surrounding logic. This is the DUT stage driven by the team's clocked test bench.
- Outputs feed display/seven-segment decoding downstream.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- TICK_FREQ, 100, tick rate in Hz. DIV = CLOCK_FREQ/TICK_FREQ must be an integer ≥2; otherwise elaboration fails via a generate-time error.
- NUM_DIGITS, 4, number of BCD digits counted.

Ports:
- clock  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
- start  input  1  level; run request.
- stop  input  1  level; pause request.
- clear  input  1  level; return to zero/idle.
- running  output  1  high while in RUNNING.
- tick  output  1  one-cycle pulse per counted tick.
- count  output  4*NUM_DIGITS  BCD count; digit 0 is in bits [3:0].
- overflow  output  1  sticky; set when count wraps from all 9s.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; prescaler=0; count=0; tick=0; running=0; overflow=0.
- Controls are sampled every rising edge. Priority is clear > stop > start.
- States:
  - IDLE: count and prescaler are held at 0. start → RUNNING (prescaler stays 0). stop or clear → stay in IDLE.
  - RUNNING: on each edge, if the prescaler is DIV-1, the prescaler wraps to 0, tick is registered high for that cycle, and count increments, all on the same edge. Otherwise the prescaler increments and tick is 0. stop → PAUSED. clear → IDLE.
  - PAUSED: prescaler, count and overflow hold; tick=0. start → RUNNING, resuming from the held prescaler value. clear → IDLE.
- Boundary and simultaneity rules:
  - If stop is sampled on the edge where the prescaler is DIV-1, stop wins: no tick, and the prescaler holds DIV-1. The tick then occurs on the first edge after resume.
  - clear on a terminal edge: no tick, and count, prescaler and overflow go to 0.
- Latency: the first tick occurs DIV edges after the edge that samples start in IDLE.
- BCD arithmetic:
  - Each digit counts 0–9 and carries to the next digit when it is 9 and incrementing.
  - The all-9s count plus one wraps to all 0s and sets overflow. overflow stays set until clear or reset.
- running is a registered decode of state; tick is registered.
- Prescaler width is $clog2(DIV).
- Asserting reset mid-run returns outputs to reset values immediately. Operation resumes only via a new start after reset is released.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding constants IDLE/RUNNING/PAUSED (2-bit);
  - BCD_MAX = 4'd9;
  - the DIV computation function.
- Sub-module bcd_digit_counter: one digit with ports clock, reset, clear, inc, digit[3:0], carry_out. carry_out = inc && digit==9.
- bcd_digit_counter is instantiated NUM_DIGITS times in a generate loop. Each inc is chained from the previous carry_out; digit 0 inc = tick_enable.
- Prescaler and FSM are implemented inline in stopwatch_timer.

Test Plan (CLOCK_FREQ=50000000, TICK_FREQ=10000000 so DIV=5, NUM_DIGITS=2):
1. reset=0 for 2 cycles, then 1 → count=8'h00, tick=0, running=0, overflow=0. running stays 0 with no start.
2. One-cycle start pulse, then run 50 edges → tick high every 5th edge; first tick 5 edges after the start edge; count=8'h10 after 10 ticks; running=1 throughout.
3. stop when count=8'h03 and prescaler=2; hold 20 cycles → count stays 8'h03, tick=0, running=0. Then pulse start → tick on the 3rd edge after resume; count=8'h04.
4. Run to count=8'h99, then one more tick → count=8'h00, overflow=1; overflow still 1 after 10 further ticks; clear → count=8'h00, overflow=0, state IDLE.
5. While RUNNING, assert start+stop+clear in one cycle → next edge: IDLE, count=8'h00, running=0. In IDLE, assert start+stop → remains IDLE, count=8'h00.
6. Drive reset low between clock edges while RUNNING with count=8'h07 → count=0, tick=0, running=0 immediately, before the next edge. After release, no counting occurs until start.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding, BCD limit, divider helpers.
// No logic of its own; pure types, constants and elaboration-time functions.
// Not applicable (no datapath).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Clock cycles per tick; guarded so a zero tick rate cannot divide by zero.
  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned tick_freq);
    return (tick_freq == 0) ? 0 : clock_freq / tick_freq;
  endfunction

  // The divider must be an exact integer and at least 2.
  function automatic bit div_ok(input int unsigned clock_freq,
                                input int unsigned tick_freq);
    return (tick_freq != 0) && (clock_freq % tick_freq == 0) &&
           (clock_freq / tick_freq >= 2);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit (0-9) with synchronous clear and carry to the next digit.
// Digit updates on the edge where inc is high; carry_out is combinational.
// No backpressure; inc is a single-cycle enable from the previous stage.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: clear wins, otherwise wrap 9 -> 0 on increment.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Digit register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = inc && (digit_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch: prescaler makes a tick every DIV clocks while RUNNING; BCD chain counts ticks.
// Tick, count and overflow update on the same edge; first tick DIV edges after start.
// Level controls, priority clear > stop > start; stop on a terminal edge suppresses the tick.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned TICK_FREQ  = 100,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  output logic                    running,
  output logic                    tick,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    overflow
);

  localparam int unsigned DIV = calc_div(CLOCK_FREQ, TICK_FREQ);
  localparam int unsigned PW  = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  if (!div_ok(CLOCK_FREQ, TICK_FREQ)) begin : g_bad_div
    $error("stopwatch_timer: CLOCK_FREQ/TICK_FREQ must be an integer >= 2");
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_q, tick_d;
  logic            running_q;
  logic            overflow_q, overflow_d;
  logic            terminal;
  logic            digit_clr;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] inc;

  assign terminal  = (presc_q == PS_LAST);
  // Count is held at zero whenever the watch is idle, not just on the clear edge.
  assign digit_clr = clear || (state_q == IDLE);

  // Next state, prescaler, tick and sticky overflow; clear beats stop beats start.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    overflow_d = overflow_q;
    if (clear) begin
      state_d    = IDLE;
      presc_d    = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (!stop && start) state_d = RUNNING;
        end
        RUNNING: begin
          // Stop freezes the prescaler where it is, even at DIV-1.
          if (stop) begin
            state_d = PAUSED;
          end else if (terminal) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (carry[NUM_DIGITS-1]) overflow_d = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSED: begin
          if (!stop && start) state_d = RUNNING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers; running is a registered decode of the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == RUNNING);
      overflow_q <= overflow_d;
    end
  end

  // Ripple-enable chain: digit 0 advances on tick, each higher digit on the carry below.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_first
      assign inc[g] = tick_d;
    end else begin : g_rest
      assign inc[g] = carry[g-1];
    end
    bcd_digit_counter u_digit (
      .clock     (clock),
      .reset     (reset),
      .clear     (digit_clr),
      .inc       (inc[g]),
      .digit     (count[4*g +: 4]),
      .carry_out (carry[g])
    );
  end

  assign running  = running_q;
  assign tick     = tick_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Self-checking bench: directed scenarios plus random controls against a decimal reference model.
// Expected outputs per clock edge are queued at the edge and checked by a monitor at negedge.
// Model tracks only run/idle, phase since last tick, decimal count and overflow.
module tb_stopwatch_timer;

  localparam int unsigned CLOCK_FREQ = 50000000;
  localparam int unsigned TICK_FREQ  = 10000000;
  localparam int unsigned NUM_DIGITS = 2;
  localparam int DIV = 5;

  typedef struct packed {
    logic       running;
    logic       tick;
    logic [7:0] count;
    logic       ovf;
  } snap_t;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       clear;
  logic       running;
  logic       tick;
  logic [7:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  snap_t exp_q[$];

  // Reference model state.
  bit m_run;
  int m_ph;
  int m_cnt;
  bit m_ovf;
  bit m_tick;

  stopwatch_timer #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .TICK_FREQ  (TICK_FREQ),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .running  (running),
    .tick     (tick),
    .count    (count),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.running = m_run;
    s.tick    = m_tick;
    s.count   = to_bcd(m_cnt);
    s.ovf     = m_ovf;
    return s;
  endfunction

  task automatic model_zero();
    m_run = 0; m_ph = 0; m_cnt = 0; m_ovf = 0; m_tick = 0;
  endtask

  // One clock edge of stopwatch behaviour as seen from outside.
  task automatic model_edge(input bit s, input bit p, input bit c, input bit rst_n);
    m_tick = 0;
    if (!rst_n || c) begin
      model_zero();
    end else if (p) begin
      m_run = 0;
    end else if (m_run) begin
      if (m_ph == DIV - 1) begin
        m_ph   = 0;
        m_tick = 1;
        if (m_cnt == 99) m_ovf = 1;
        m_cnt  = (m_cnt + 1) % 100;
      end else begin
        m_ph = m_ph + 1;
      end
    end else if (s) begin
      m_run = 1;
    end
  endtask

  // Drive controls for one edge, update the model at the edge, queue expectation.
  task automatic cyc(input bit s, input bit p, input bit c);
    start = s; stop = p; clear = c;
    @(posedge clock);
    model_edge(s, p, c, reset);
    exp_q.push_back(model_snap());
    #1;
    start = 0; stop = 0; clear = 0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: cycle budget exhausted at %0t", name, $time);
  endtask

  // Monitor: compare every mid-cycle DUT snapshot against the queued expectation.
  initial begin
    snap_t e;
    snap_t g;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {running, tick, count, overflow};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL snap: got run=%b tick=%b cnt=%h ovf=%b expected run=%b tick=%b cnt=%h ovf=%b at %0t",
                   g.running, g.tick, g.count, g.ovf, e.running, e.tick, e.count, e.ovf, $time);
        end
      end
    end
  end

  initial begin
    int n;
    bit hit;
    model_zero();
    start = 0; stop = 0; clear = 0;
    reset = 0;

    // 1. Reset state and idle without start.
    repeat (2) @(posedge clock);
    #1 reset = 1;
    chk("rst_count", 16'(count), 16'h00);
    chk("rst_flags", {13'd0, running, tick, overflow}, 16'd0);
    repeat (5) cyc(0, 0, 0);
    chk("idle_running", 16'(running), 16'd0);

    // 2. Start pulse, 50 edges -> 10 ticks.
    cyc(1, 0, 0);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      cyc(0, 0, 0);
      if (tick) n++;
      if (i == 5) chk("first_tick", 16'(tick), 16'd1);
      if (i == 4) chk("pre_first_tick", 16'(tick), 16'd0);
    end
    chk("ticks_50", 16'(n), 16'd10);
    chk("count_10", 16'(count), 16'h10);
    chk("running_2", 16'(running), 16'd1);

    // 3. Pause at count 03 / prescaler 2, resume.
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (m_cnt == 3 && m_ph == 2) hit = 1;
      else cyc(0, 0, 0);
    end
    if (!hit) fail_bound("reach_03");
    cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    chk("pause_count", 16'(count), 16'h03);
    chk("pause_run_tick", {14'd0, running, tick}, 16'd0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("resume_no_tick", 16'(tick), 16'd0);
    cyc(0, 0, 0);
    chk("resume_tick", 16'(tick), 16'd1);
    chk("resume_count", 16'(count), 16'h04);

    // Stop on a terminal edge suppresses the tick; it lands right after resume.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_ph == DIV - 1) hit = 1;
      else cyc(0, 0, 0);
    end
    if (!hit) fail_bound("reach_term_stop");
    cyc(0, 1, 0);
    chk("term_stop_tick", 16'(tick), 16'd0);
    chk("term_stop_count", 16'(count), 16'h04);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("term_resume_tick", 16'(tick), 16'd1);
    chk("term_resume_count", 16'(count), 16'h05);

    // Clear on a terminal edge: no tick, all zero.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_ph == DIV - 1) hit = 1;
      else cyc(0, 0, 0);
    end
    if (!hit) fail_bound("reach_term_clear");
    cyc(0, 0, 1);
    chk("term_clear", {7'd0, running, tick, count[6:0]}, 16'd0);

    // 4. Run to 99, wrap, sticky overflow, clear.
    cyc(1, 0, 0);
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (m_cnt == 99) hit = 1;
      else cyc(0, 0, 0);
    end
    if (!hit) fail_bound("reach_99");
    chk("count_99", 16'(count), 16'h99);
    chk("ovf_before_wrap", 16'(overflow), 16'd0);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc(0, 0, 0);
      if (m_tick) hit = 1;
    end
    if (!hit) fail_bound("wrap_tick");
    chk("wrap_count", 16'(count), 16'h00);
    chk("wrap_ovf", 16'(overflow), 16'd1);
    repeat (10 * DIV) cyc(0, 0, 0);
    chk("ovf_sticky", 16'(overflow), 16'd1);
    chk("ovf_count", 16'(count), 16'h10);
    cyc(0, 0, 1);
    chk("clear_all", {13'd0, running, tick, overflow}, 16'd0);
    chk("clear_count", 16'(count), 16'h00);

    // 5. All controls together while running; start+stop in idle.
    cyc(1, 0, 0);
    repeat (12) cyc(0, 0, 0);
    cyc(1, 1, 1);
    chk("ssc_running", 16'(running), 16'd0);
    chk("ssc_count", 16'(count), 16'h00);
    cyc(1, 1, 0);
    repeat (8) cyc(0, 0, 0);
    chk("ss_idle_running", 16'(running), 16'd0);
    chk("ss_idle_count", 16'(count), 16'h00);

    // 6. Asynchronous reset mid-run at count 07.
    cyc(1, 0, 0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_cnt == 7) hit = 1;
      else cyc(0, 0, 0);
    end
    if (!hit) fail_bound("reach_07");
    chk("pre_reset_count", 16'(count), 16'h07);
    reset = 0;
    model_zero();
    // Reset lands mid-cycle, so the pending snapshot for this cycle is the reset state.
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(model_snap());
    #1;
    chk("async_reset", {5'd0, running, tick, overflow, count}, 16'd0);
    repeat (3) cyc(0, 0, 0);
    reset = 1;
    repeat (10) cyc(0, 0, 0);
    chk("post_reset_idle", {7'd0, running, count}, 16'd0);
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    chk("post_reset_run", 16'(count), 16'h02);

    // Random control soak against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 63) == 0));
    end

    @(negedge clock);
    #1;
    chk("drain", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
